// File: rtl/pi_phase_ctrl.sv
// pi_phase_ctrl: phase-select controller for the mainband phase interpolator.
// Track mode steps the 4-bit code from early/late votes; sweep mode walks all
// 16 codes, records comparator results and parks at the widest passing window.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   i_mode[1:0]      00 hold, 01 track, 10 sweep, 11 hold
//   i_early/i_late   phase detector votes
//   i_sweep_start    sweep start pulse (mode 10, idle only)
//   i_cmp_pass       pattern comparator result
//   o_step_sel[3:0]  PI phase code
//   o_code_stable    code neither settling nor sweeping
//   o_busy           sweep in progress
//   o_sweep_done     one-cycle completion pulse
//   o_sweep_fail     no code passed in the last sweep
//   o_best_code[3:0] centre code of the last sweep
//   o_eye_width[4:0] longest circular pass run
module pi_phase_ctrl #(
  parameter int unsigned THRESH     = 8,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_mode,
  input  logic       i_early,
  input  logic       i_late,
  input  logic       i_sweep_start,
  input  logic       i_cmp_pass,
  output logic [3:0] o_step_sel,
  output logic       o_code_stable,
  output logic       o_busy,
  output logic       o_sweep_done,
  output logic       o_sweep_fail,
  output logic [3:0] o_best_code,
  output logic [4:0] o_eye_width
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SET    = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_EVAL   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic signed [5:0] TH_POS = 6'(THRESH);
  localparam logic signed [5:0] TH_NEG = -TH_POS;

  logic [2:0]        state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [15:0]       mask_q, mask_d;
  logic [3:0]        run_start_q, run_start_d;
  logic [4:0]        run_len_q, run_len_d;
  logic [3:0]        best_start_q, best_start_d;
  logic [4:0]        best_len_q, best_len_d;
  logic [3:0]        restore_q, restore_d;
  logic signed [5:0] acc_q, acc_d;
  logic [3:0]        settle_q, settle_d;
  logic [3:0]        step_sel_q, step_sel_d;
  logic              code_stable_q, code_stable_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic [3:0]        best_code_q, best_code_d;
  logic [4:0]        eye_width_q, eye_width_d;

  logic signed [5:0] vote;
  logic              eval_bit;
  logic [4:0]        new_len;
  logic [3:0]        new_start;
  logic [3:0]        centre;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      k_q           <= 4'd0;
      cnt_q         <= 5'd0;
      mask_q        <= 16'd0;
      run_start_q   <= 4'd0;
      run_len_q     <= 5'd0;
      best_start_q  <= 4'd0;
      best_len_q    <= 5'd0;
      restore_q     <= 4'd0;
      acc_q         <= 6'sd0;
      settle_q      <= 4'd0;
      step_sel_q    <= 4'd0;
      code_stable_q <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
      best_code_q   <= 4'd0;
      eye_width_q   <= 5'd0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      run_start_q   <= run_start_d;
      run_len_q     <= run_len_d;
      best_start_q  <= best_start_d;
      best_len_q    <= best_len_d;
      restore_q     <= restore_d;
      acc_q         <= acc_d;
      settle_q      <= settle_d;
      step_sel_q    <= step_sel_d;
      code_stable_q <= code_stable_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fail_q        <= fail_d;
      best_code_q   <= best_code_d;
      eye_width_q   <= eye_width_d;
    end
  end

  // Next-state: tracking loop, sweep sequencer and window evaluation
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    restore_d    = restore_q;
    acc_d        = acc_q;
    settle_d     = settle_q;
    step_sel_d   = step_sel_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    fail_d       = fail_q;
    best_code_d  = best_code_q;
    eye_width_d  = eye_width_q;
    vote         = 6'sd0;
    eval_bit     = 1'b0;
    new_len      = 5'd0;
    new_start    = 4'd0;
    centre       = 4'd0;

    if (i_early && !i_late) begin
      vote = 6'sd1;
    end else if (i_late && !i_early) begin
      vote = -6'sd1;
    end

    if (state_q == S_IDLE) begin
      if (busy_q) begin
        // Cycle after DONE: busy drops, votes still ignored
        busy_d = 1'b0;
      end else if (i_sweep_start && (i_mode == 2'b10)) begin
        restore_d  = step_sel_q;
        k_d        = 4'd0;
        step_sel_d = 4'd0;
        fail_d     = 1'b0;
        busy_d     = 1'b1;
        acc_d      = 6'sd0;
        settle_d   = 4'd0;
        mask_d     = 16'd0;
        state_d    = S_SET;
      end else if (settle_q != 4'd0) begin
        settle_d = settle_q - 4'd1;
        acc_d    = 6'sd0;
      end else if (i_mode == 2'b01) begin
        // Crossing is taken from the registered accumulator
        if (acc_q >= TH_POS) begin
          step_sel_d = step_sel_q + 4'd1;
          acc_d      = 6'sd0;
          settle_d   = 4'(SETTLE_CYC);
        end else if (acc_q <= TH_NEG) begin
          step_sel_d = step_sel_q - 4'd1;
          acc_d      = 6'sd0;
          settle_d   = 4'(SETTLE_CYC);
        end else begin
          acc_d = acc_q + vote;
        end
      end else begin
        acc_d = 6'sd0;
      end
    end else if (i_mode != 2'b10) begin
      // Abort: restore the pre-sweep code without a done pulse
      state_d    = S_IDLE;
      busy_d     = 1'b0;
      step_sel_d = restore_q;
    end else begin
      case (state_q)
        S_SET: begin
          cnt_d   = 5'(SETTLE_CYC - 1);
          state_d = S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == 5'd0) begin
            state_d = S_SAMPLE;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        S_SAMPLE: begin
          mask_d[k_q] = i_cmp_pass;
          if (k_q == 4'd15) begin
            cnt_d        = 5'd0;
            run_start_d  = 4'd0;
            run_len_d    = 5'd0;
            best_start_d = 4'd0;
            best_len_d   = 5'd0;
            state_d      = S_EVAL;
          end else begin
            k_d        = k_q + 4'd1;
            step_sel_d = k_q + 4'd1;
            state_d    = S_SET;
          end
        end
        S_EVAL: begin
          // Two laps over the mask so runs crossing 15->0 are seen whole
          eval_bit = mask_q[cnt_q[3:0]];
          if (eval_bit) begin
            new_start   = (run_len_q == 5'd0) ? cnt_q[3:0] : run_start_q;
            new_len     = (run_len_q == 5'd16) ? 5'd16 : run_len_q + 5'd1;
            run_start_d = new_start;
            run_len_d   = new_len;
            if (new_len > best_len_q) begin
              best_len_d   = new_len;
              best_start_d = new_start;
            end
          end else begin
            run_len_d = 5'd0;
          end
          if (cnt_q == 5'd31) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
        S_DONE: begin
          done_d      = 1'b1;
          eye_width_d = best_len_q;
          if (best_len_q != 5'd0) begin
            centre      = best_start_q + 4'((best_len_q - 5'd1) >> 1);
            best_code_d = centre;
            step_sel_d  = centre;
          end else begin
            fail_d     = 1'b1;
            step_sel_d = restore_q;
          end
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  assign code_stable_d = !busy_d && (settle_d == 4'd0);

  assign o_step_sel    = step_sel_q;
  assign o_code_stable = code_stable_q;
  assign o_busy        = busy_q;
  assign o_sweep_done  = done_q;
  assign o_sweep_fail  = fail_q;
  assign o_best_code   = best_code_q;
  assign o_eye_width   = eye_width_q;

endmodule

// File: tb/tb_pi_phase_ctrl.sv
// Directed testbench for pi_phase_ctrl (THRESH=8, SETTLE_CYC=4).
module tb_pi_phase_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic       early;
  logic       late;
  logic       start;
  logic       cmp_pass;
  logic [3:0] step_sel;
  logic       code_stable;
  logic       busy;
  logic       done;
  logic       fail;
  logic [3:0] best_code;
  logic [4:0] eye_width;

  logic [15:0] tb_mask;
  int checks;
  int errors;

  pi_phase_ctrl #(.THRESH(8), .SETTLE_CYC(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_mode        (mode),
    .i_early       (early),
    .i_late        (late),
    .i_sweep_start (start),
    .i_cmp_pass    (cmp_pass),
    .o_step_sel    (step_sel),
    .o_code_stable (code_stable),
    .o_busy        (busy),
    .o_sweep_done  (done),
    .o_sweep_fail  (fail),
    .o_best_code   (best_code),
    .o_eye_width   (eye_width)
  );

  // Comparator model: passes for codes whose bit is set in tb_mask
  assign cmp_pass = tb_mask[step_sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Full sweep from the current cycle (cycle 0 = start pulse); a stray start
  // pulse mid-sweep must be ignored
  task automatic run_sweep(input string tag, input logic [15:0] mask,
                           input logic [4:0] exp_w, input logic [3:0] exp_code,
                           input logic exp_fail);
    tb_mask = mask;
    mode    = 2'b10;
    start   = 1'b1;
    for (int c = 1; c <= 131; c++) begin
      step();
      if (c == 1) begin
        start = 1'b0;
        chk({tag, "_busy_c1"}, 32'(busy), 32'd1);
        chk({tag, "_fail_clr"}, 32'(fail), 32'd0);
        chk({tag, "_sel_c1"}, 32'(step_sel), 32'd0);
        chk({tag, "_stable_c1"}, 32'(code_stable), 32'd0);
      end
      if (c == 20) start = 1'b1;
      if (c == 21) start = 1'b0;
      chk({tag, "_done"}, 32'(done), (c == 130) ? 32'd1 : 32'd0);
      if (c == 130) begin
        chk({tag, "_width"}, 32'(eye_width), 32'(exp_w));
        chk({tag, "_best"}, 32'(best_code), 32'(exp_code));
        chk({tag, "_sel"}, 32'(step_sel), 32'(exp_code));
        chk({tag, "_failflag"}, 32'(fail), 32'(exp_fail));
        chk({tag, "_busy_c130"}, 32'(busy), 32'd1);
      end
      if (c == 131) begin
        chk({tag, "_busy_c131"}, 32'(busy), 32'd0);
        chk({tag, "_stable_c131"}, 32'(code_stable), 32'd1);
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sel"}, 32'(step_sel), 32'd0);
    chk({tag, "_stable"}, 32'(code_stable), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_fail"}, 32'(fail), 32'd0);
    chk({tag, "_best"}, 32'(best_code), 32'd0);
    chk({tag, "_width"}, 32'(eye_width), 32'd0);
  endtask

  initial begin
    int done_seen;
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    mode    = 2'b00;
    early   = 1'b0;
    late    = 1'b0;
    start   = 1'b0;
    tb_mask = 16'h0000;
    step();
    step();
    chk_reset("reset");
    rst  = 1'b0;
    mode = 2'b01;
    step();

    // Track wrap-down 0 -> 15: late from cycle 0, code changes at cycle 9
    late = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 8) chk("dn_c8", 32'(step_sel), 32'd0);
      if (c == 9) chk("dn_c9", 32'(step_sel), 32'd15);
    end
    late = 1'b0;
    idle(6);
    chk("dn_settled", 32'(code_stable), 32'd1);

    // Track wrap-up 15 -> 0 at cycle 9, stable low 9..12, next step at 22
    early = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      step();
      chk("up_sel", 32'(step_sel), (c < 9) ? 32'd15 : ((c < 22) ? 32'd0 : 32'd1));
      chk("up_stable", 32'(code_stable), ((c >= 9 && c <= 12) || c == 22) ? 32'd0 : 32'd1);
    end
    early = 1'b0;
    idle(6);

    // Cancel: both votes for 50 cycles leave code and accumulator alone
    early = 1'b1;
    late  = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      step();
      chk("cancel_sel", 32'(step_sel), 32'd1);
    end
    late = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 8) chk("cancel_c8", 32'(step_sel), 32'd1);
      if (c == 9) chk("cancel_c9", 32'(step_sel), 32'd2);
    end
    early = 1'b0;
    idle(6);

    // Hold clears a partial accumulator and freezes the code
    early = 1'b1;
    idle(5);
    mode = 2'b00;
    for (int c = 1; c <= 20; c++) begin
      step();
      chk("hold_sel", 32'(step_sel), 32'd2);
    end
    mode = 2'b11;
    idle(2);
    mode = 2'b01;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 8) chk("hold_c8", 32'(step_sel), 32'd2);
      if (c == 9) chk("hold_c9", 32'(step_sel), 32'd3);
    end
    early = 1'b0;
    idle(6);

    // Sweeps
    run_sweep("sw_mid", 16'h03F0, 5'd6, 4'd6, 1'b0);
    run_sweep("sw_wrap", 16'hC007, 5'd5, 4'd0, 1'b0);
    run_sweep("sw_all", 16'hFFFF, 5'd16, 4'd7, 1'b0);
    run_sweep("sw_one", 16'h0200, 5'd1, 4'd9, 1'b0);
    run_sweep("sw_none", 16'h0000, 5'd0, 4'd9, 1'b1);

    // Start outside sweep mode is ignored; fail flag persists
    mode  = 2'b01;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("ign_busy", 32'(busy), 32'd0);
    chk("ign_sel", 32'(step_sel), 32'd9);
    chk("ign_fail", 32'(fail), 32'd1);
    step();

    run_sweep("sw_three", 16'h0008, 5'd1, 4'd3, 1'b0);

    // Abort at cycle 40 restores code 3 with no done pulse
    tb_mask = 16'hFFFF;
    mode    = 2'b10;
    start   = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 1) start = 1'b0;
    end
    mode = 2'b01;
    step();
    chk("abort_sel", 32'(step_sel), 32'd3);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_stable", 32'(code_stable), 32'd1);
    done_seen = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (done) done_seen++;
    end
    chk("abort_nodone", 32'(done_seen), 32'd0);
    chk("abort_sel_late", 32'(step_sel), 32'd3);

    // Reset at cycle 60 of a sweep
    mode  = 2'b10;
    start = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (c == 1) start = 1'b0;
    end
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    chk_reset("midrst");
    rst  = 1'b0;
    mode = 2'b00;
    step();
    chk_reset("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pi_phase_ctrl.md
# pi_phase_ctrl

Digital controller that produces the 4-bit phase-select code for the mainband phase interpolator. In track mode it accumulates early/late votes from the lane phase detector and steps the code with modulo-16 wrap-around. In sweep mode it walks all 16 codes during training, records comparator pass/fail per code, and parks the PI at the centre of the widest circular passing window. It sits directly upstream of the PI, with `o_step_sel` wired straight to the PI `step_sel` input.

## Interface
- `THRESH`, 8: vote-accumulator magnitude that triggers one code step (range 1..31).
- `SETTLE_CYC`, 4: cycles waited after every code change before votes or samples are used (range 1..15).
- `clk` in 1: controller clock.
- `rst` in 1: reset; synchronous and active-high.
- `i_mode` in 2: 00 hold, 01 track, 10 sweep, 11 treated as hold.
- `i_early` in 1: phase detector early vote, one per cycle.
- `i_late` in 1: phase detector late vote, one per cycle.
- `i_sweep_start` in 1: single-cycle pulse; starts a sweep when `i_mode`=10 and the controller is idle.
- `i_cmp_pass` in 1: pattern-comparator result, sampled in the SAMPLE state.
- `o_step_sel` out 4: PI phase code.
- `o_code_stable` out 1: high when the code is neither settling nor sweeping.
- `o_busy` out 1: high while a sweep is in progress.
- `o_sweep_done` out 1: one-cycle pulse at sweep completion.
- `o_sweep_fail` out 1: set with done when no code passed; cleared at the next sweep start.
- `o_best_code` out 4: centre code from the last sweep.
- `o_eye_width` out 5: longest circular pass run, 0..16.

## Operation
- Reset values:
  - `o_step_sel`=0, `o_code_stable`=1, `o_busy`=0, `o_sweep_done`=0, `o_sweep_fail`=0, `o_best_code`=0, `o_eye_width`=0.
  - Accumulator=0, settle counter=0, FSM=IDLE.
- Hold (00/11): code frozen; accumulator cleared.
- Track (01):
  - Per cycle, the signed 6-bit accumulator takes +1 for early only, -1 for late only, 0 for both or neither.
  - Accumulator >= `THRESH`: code +1 mod 16 (15 -> 0). Accumulator <= -`THRESH`: code -1 mod 16 (0 -> 15).
  - On either step: accumulator cleared, settle counter loaded with `SETTLE_CYC`, `o_code_stable`=0.
  - While settling, votes are ignored and the accumulator is held at 0.
- Sweep FSM states: IDLE -> SET -> SETTLE -> SAMPLE -> (SET | EVAL) -> DONE -> IDLE.
  - IDLE: `i_sweep_start` with mode 10 saves the current code as the restore code, sets k=0, clears `o_sweep_fail`, and raises `o_busy`.
  - SET: `o_step_sel`=k (1 cycle).
  - SETTLE: `SETTLE_CYC` cycles.
  - SAMPLE: pass_mask[k]=`i_cmp_pass` (1 cycle). If k=15, go to EVAL; else k+1 and go to SET.
  - EVAL: scan indices 0..31 over pass_mask[i mod 16], one per cycle (32 cycles).
    - Track the current run start and length; the length saturates at 16.
    - Record the best run on strictly-greater length, so on ties the earliest start wins.
  - DONE (1 cycle): pulse `o_sweep_done`; load `o_eye_width`.
    - Width > 0: `o_best_code` = (start + (width-1)/2) mod 16, and `o_step_sel` = best code.
    - Width = 0: `o_sweep_fail`=1, `o_best_code` unchanged, `o_step_sel` = restore code.
- Abort: if `i_mode` leaves 10 while busy, go to IDLE next cycle, restore the code, no done pulse, `o_busy`=0.
- `i_sweep_start` while busy, or in a mode other than 10: ignored.
- Track votes are ignored while busy.

## Timing
- Track step latency:
  - The threshold crossing is registered; the code changes the cycle after the accumulator reaches ±`THRESH`.
  - Example: `THRESH` consecutive early-only cycles starting at cycle 0 -> code changes at cycle `THRESH`+1.
- `o_code_stable` drops in the same cycle the code changes and rises after `SETTLE_CYC` cycles.
- Sweep length:
  - Start pulse at cycle 0, `o_busy`=1 from cycle 1.
  - Sampling takes 16×(`SETTLE_CYC`+2) cycles, followed by 32 EVAL cycles and a 1-cycle DONE.
  - Default total: 1 + 96 + 32 + 1 = 130 cycles to the `o_sweep_done` pulse; `o_busy` falls the cycle after.
- `rst` mid-sweep or mid-settle: all outputs return to reset values on the next clock edge.
- All outputs are registered.

## Test plan
- Track wrap-up: code 15, `THRESH`=8, early held high -> code 0 at cycle 9; `o_code_stable` low for 4 cycles; next step at cycle 9+4+8+1.
- Track cancel: early and late both high for 50 cycles -> code unchanged, accumulator stays 0.
- Sweep: pass mask 0x03F0 (codes 4..9) -> `o_eye_width`=6, `o_best_code`=6, `o_step_sel`=6, done at cycle 130.
- Circular window: pass at codes 14,15,0,1,2 -> width 5, best code 0.
- All-fail: mask 0x0000, code 9 before sweep -> `o_sweep_fail`=1, width 0, `o_step_sel`=9.
- Abort: mode to 01 at cycle 40 of a sweep from code 3 -> `o_step_sel`=3, `o_busy`=0, no done pulse. Separately, `rst` at cycle 60 -> all outputs at reset values.
